// File: rtl/mem_arbiter.sv
// Arbiter that lets one byte-wide RAM serve an instruction-fetch port and a load/store port.
// Word fetches and multi-byte data accesses are serialised into byte reads and writes.
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_done_o,
    input  logic              io_stall_i,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

    state_e            state_q;
    logic [2:0]        issueCnt_q;
    logic [2:0]        captureCnt_q;
    logic [2:0]        nBytes_q;
    logic [ADDR_W-1:0] ramAddr_q;
    logic [7:0]        ramDout_q;
    logic              ramWr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdBuf_q;
    logic [31:0]       rdBuf_d;
    logic [31:0]       ifData_q;
    logic [31:0]       memData_q;
    logic              ifDone_q;
    logic              memDone_q;
    logic [2:0]        memBytes;

    always_comb begin
        memBytes = (mem_len_i == 2'd0) ? 3'd1 : (mem_len_i == 2'd1) ? 3'd2 : 3'd4;
    end

    // The byte returned this cycle belongs to the lane named by the capture counter.
    always_comb begin
        rdBuf_d = rdBuf_q;
        rdBuf_d[{captureCnt_q[1:0], 3'b000} +: 8] = ram_din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            issueCnt_q   <= 3'd0;
            captureCnt_q <= 3'd0;
            nBytes_q     <= 3'd0;
            ramAddr_q    <= '0;
            ramDout_q    <= 8'd0;
            ramWr_q      <= 1'b0;
            wdata_q      <= 32'd0;
            rdBuf_q      <= 32'd0;
            ifData_q     <= 32'd0;
            memData_q    <= 32'd0;
            ifDone_q     <= 1'b0;
            memDone_q    <= 1'b0;
        end else begin
            ifDone_q  <= 1'b0;
            memDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req_i) begin
                        state_q      <= mem_wr_i ? MEM_WR : MEM_RD;
                        ramAddr_q    <= mem_addr_i;
                        nBytes_q     <= memBytes;
                        wdata_q      <= mem_wdata_i;
                        ramWr_q      <= mem_wr_i;
                        if (mem_wr_i) ramDout_q <= mem_wdata_i[7:0];
                        issueCnt_q   <= 3'd1;
                        captureCnt_q <= 3'd0;
                        rdBuf_q      <= 32'd0;
                    end else if (if_req_i && !if_abort_i) begin
                        state_q      <= IF_RD;
                        ramAddr_q    <= if_addr_i;
                        nBytes_q     <= 3'd4;
                        issueCnt_q   <= 3'd1;
                        captureCnt_q <= 3'd0;
                        rdBuf_q      <= 32'd0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_q == IF_RD && if_abort_i) begin
                        state_q      <= IDLE;
                        issueCnt_q   <= 3'd0;
                        captureCnt_q <= 3'd0;
                    end else begin
                        // Issue runs one count past the last address so the final byte can land.
                        if (issueCnt_q < nBytes_q) ramAddr_q <= ramAddr_q + ADDR_W'(1);
                        issueCnt_q <= issueCnt_q + 3'd1;
                        if (issueCnt_q >= 3'd2) begin
                            rdBuf_q      <= rdBuf_d;
                            captureCnt_q <= captureCnt_q + 3'd1;
                        end
                        if (issueCnt_q == nBytes_q + 3'd1) begin
                            state_q      <= IDLE;
                            issueCnt_q   <= 3'd0;
                            captureCnt_q <= 3'd0;
                            if (state_q == IF_RD) begin
                                ifData_q <= rdBuf_d;
                                ifDone_q <= 1'b1;
                            end else begin
                                memData_q <= rdBuf_d;
                                memDone_q <= 1'b1;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    if (!io_stall_i) begin
                        if (issueCnt_q == nBytes_q) begin
                            state_q    <= IDLE;
                            ramWr_q    <= 1'b0;
                            issueCnt_q <= 3'd0;
                            memDone_q  <= 1'b1;
                        end else begin
                            ramAddr_q  <= ramAddr_q + ADDR_W'(1);
                            ramDout_q  <= wdata_q[{issueCnt_q[1:0], 3'b000} +: 8];
                            issueCnt_q <= issueCnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Back-pressure must suppress the write strobe within the very cycle it is raised.
    assign ram_wr_o   = ramWr_q & ~((state_q == MEM_WR) & io_stall_i);
    assign ram_addr_o = ramAddr_q;
    assign ram_dout_o = ramDout_q;
    assign if_data_o  = ifData_q;
    assign if_done_o  = ifDone_q;
    assign mem_data_o = memData_q;
    assign mem_done_o = memDone_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model expands each request into per-cycle
// input and expected-output records that a driver and a single checker walk in lockstep.
module tb_mem_arbiter;

    localparam int AW    = 17;
    localparam int RAMSZ = 1 << AW;

    typedef struct {
        logic          rstn, ifReq, ifAbort, memReq, memWr, stall;
        logic [AW-1:0] ifAddr, memAddr;
        logic [1:0]    len;
        logic [31:0]   wdata;
    } stim_t;

    typedef struct {
        logic          busy, ifDone, memDone, wr, chkAddr, chkDout, pinIf, pinMem;
        logic [AW-1:0] addr;
        logic [7:0]    dout;
        logic [31:0]   ifData, memData, pinVal;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_abort, mem_req, mem_wr, io_stall;
    logic [AW-1:0] if_addr, mem_addr;
    logic [1:0]    mem_len;
    logic [31:0]   mem_wdata;
    logic [7:0]    ram_din;
    logic [31:0]   if_data, mem_data;
    logic          if_done, mem_done, ram_wr, busy;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;

    logic [7:0]    tbRam  [0:RAMSZ-1];
    logic [7:0]    refRam [0:RAMSZ-1];
    logic [31:0]   mIfData, mMemData;
    logic [AW-1:0] mLastAddr;
    stim_t         stimQ[$];
    exp_t          expQ[$];
    int            tests  = 0;
    int            errors = 0;
    bit            built  = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_abort_i(if_abort),
        .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr),
        .mem_len_i(mem_len), .mem_wdata_i(mem_wdata),
        .mem_data_o(mem_data), .mem_done_o(mem_done),
        .io_stall_i(io_stall), .ram_din_i(ram_din),
        .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr),
        .busy_o(busy)
    );

    // Byte-wide RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_wr) tbRam[ram_addr] <= ram_dout;
        ram_din <= tbRam[ram_addr];
    end

    function automatic int bytesFor(input logic [1:0] len);
        return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    endfunction

    function automatic stim_t quietStim();
        stim_t s;
        s.rstn = 1'b1; s.ifReq = 1'b0; s.ifAbort = 1'($urandom_range(0, 1));
        s.memReq = 1'b0; s.memWr = 1'b0; s.stall = 1'($urandom_range(0, 1));
        s.ifAddr = AW'($urandom); s.memAddr = AW'($urandom);
        s.len = 2'($urandom_range(0, 3)); s.wdata = $urandom;
        return s;
    endfunction

    function automatic exp_t idleExp();
        exp_t e;
        e.busy = 1'b0; e.ifDone = 1'b0; e.memDone = 1'b0; e.wr = 1'b0;
        e.chkAddr = 1'b1; e.chkDout = 1'b0; e.pinIf = 1'b0; e.pinMem = 1'b0;
        e.addr = mLastAddr; e.dout = 8'd0;
        e.ifData = mIfData; e.memData = mMemData; e.pinVal = 32'd0;
        return e;
    endfunction

    task automatic pushCycle(input stim_t s, input exp_t e);
        stimQ.push_back(s);
        expQ.push_back(e);
    endtask

    task automatic setRam(input logic [AW-1:0] a, input logic [7:0] b);
        tbRam[a]  = b;
        refRam[a] = b;
    endtask

    task automatic resetCycle();
        stim_t s;
        exp_t  e;
        s = quietStim();
        s.rstn = 1'b0;
        mIfData = 32'd0; mMemData = 32'd0; mLastAddr = '0;
        e = idleExp();
        e.chkDout = 1'b1;
        pushCycle(s, e);
    endtask

    task automatic idleCycle();
        pushCycle(quietStim(), idleExp());
    endtask

    // The cycle in which the request is first presented; it is accepted at its closing edge.
    task automatic beginTxn(input stim_t s);
        stim_t c;
        c = s;
        c.ifAbort = 1'b0;
        c.stall = 1'($urandom_range(0, 1));
        pushCycle(c, idleExp());
    endtask

    task automatic pinLast(input bit isIf, input logic [31:0] v);
        if (isIf) expQ[expQ.size()-1].pinIf = 1'b1;
        else      expQ[expQ.size()-1].pinMem = 1'b1;
        expQ[expQ.size()-1].pinVal = v;
    endtask

    // Read of n bytes: address base+k-1 in cycle k, done in cycle n+2; an IF abort in cycle k ends it.
    task automatic buildRead(input bit isIf, input stim_t s, input int abortAt,
                             input logic [AW-1:0] redirect);
        stim_t         c;
        exp_t          e;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        logic [31:0]   word;
        int            n;
        base = isIf ? s.ifAddr : s.memAddr;
        n    = isIf ? 4 : bytesFor(s.len);
        word = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            word[8*i +: 8] = refRam[a];
        end
        for (int k = 1; k <= n + 1; k++) begin
            c = s;
            c.stall = 1'($urandom_range(0, 1));
            if (isIf) c.ifAbort = (k == abortAt);
            else      c.ifAbort = 1'($urandom_range(0, 1));
            if (isIf && k == abortAt) c.ifAddr = redirect;
            e = idleExp();
            e.busy = 1'b1;
            e.chkAddr = (k <= n);
            e.addr = base + AW'(k - 1);
            if (k <= n) mLastAddr = e.addr;
            pushCycle(c, e);
            if (isIf && k == abortAt) return;
        end
        c = s;
        c.ifAbort = 1'b0;
        c.stall = 1'($urandom_range(0, 1));
        if (isIf) begin c.ifReq = 1'b0; mIfData = word; end
        else      begin c.memReq = 1'b0; mMemData = word; end
        e = idleExp();
        e.ifDone = isIf;
        e.memDone = !isIf;
        pushCycle(c, e);
    endtask

    // Store: byte j is presented until a non-stalled cycle writes it; done follows the last write.
    task automatic buildWrite(input stim_t s, input logic [15:0] stallMask, input bit randStall,
                              input int rstAt);
        stim_t c;
        exp_t  e;
        int    n;
        int    j;
        int    cyc;
        n = bytesFor(s.len);
        j = 0;
        cyc = 1;
        forever begin
            c = s;
            c.ifAbort = 1'($urandom_range(0, 1));
            c.stall = randStall ? ($urandom_range(0, 2) == 0) : stallMask[cyc];
            if (cyc == rstAt) begin
                c.rstn = 1'b0; c.ifReq = 1'b0; c.memReq = 1'b0;
                mIfData = 32'd0; mMemData = 32'd0; mLastAddr = '0;
                e = idleExp();
                e.chkDout = 1'b1;
                pushCycle(c, e);
                return;
            end
            e = idleExp();
            e.busy = 1'b1;
            e.addr = s.memAddr + AW'(j);
            e.chkDout = 1'b1;
            e.dout = s.wdata[8*j +: 8];
            e.wr = !c.stall;
            mLastAddr = e.addr;
            pushCycle(c, e);
            if (!c.stall) begin
                refRam[e.addr] = e.dout;
                j++;
            end
            cyc++;
            if (j == n) break;
        end
        c = s;
        c.memReq = 1'b0;
        c.ifAbort = 1'b0;
        c.stall = 1'($urandom_range(0, 1));
        e = idleExp();
        e.memDone = 1'b1;
        pushCycle(c, e);
    endtask

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 3) == 0) return AW'(RAMSZ - $urandom_range(1, 4));
        return AW'($urandom);
    endfunction

    task automatic applyStimulus(input stim_t s);
        rst_n = s.rstn; if_req = s.ifReq; if_abort = s.ifAbort; if_addr = s.ifAddr;
        mem_req = s.memReq; mem_wr = s.memWr; mem_addr = s.memAddr; mem_len = s.len;
        mem_wdata = s.wdata; io_stall = s.stall;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req,
                               input int cyc);
        tests++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Build the whole scenario up front, then drive one record per cycle just after each rising edge.
    initial begin
        stim_t s;
        int    kind;
        rst_n = 1'b0; if_req = 1'b0; if_abort = 1'b0; if_addr = '0; mem_req = 1'b0;
        mem_wr = 1'b0; mem_addr = '0; mem_len = 2'd0; mem_wdata = 32'd0; io_stall = 1'b0;
        for (int i = 0; i < RAMSZ; i++) setRam(AW'(i), 8'($urandom));
        setRam(AW'('h100), 8'h13); setRam(AW'('h101), 8'h00);
        setRam(AW'('h102), 8'h00); setRam(AW'('h103), 8'h00);
        setRam(AW'('h20), 8'hFF);
        setRam(AW'('h200), 8'h78); setRam(AW'('h201), 8'h56);
        setRam(AW'('h202), 8'h34); setRam(AW'('h203), 8'h12);
        setRam(AW'('h40), 8'h11); setRam(AW'('h41), 8'h22);
        setRam(AW'('h42), 8'h33); setRam(AW'('h43), 8'h44);
        setRam(AW'(RAMSZ - 2), 8'h01); setRam(AW'(RAMSZ - 1), 8'h02);
        setRam(AW'(0), 8'h03); setRam(AW'(1), 8'h04);
        mIfData = 32'd0; mMemData = 32'd0; mLastAddr = '0;

        resetCycle(); resetCycle(); idleCycle(); idleCycle();

        s = quietStim(); s.ifReq = 1'b1; s.ifAddr = AW'('h100);
        beginTxn(s); buildRead(1'b1, s, 0, '0); pinLast(1'b1, 32'h0000_0013);

        s = quietStim(); s.memReq = 1'b1; s.memWr = 1'b0; s.memAddr = AW'('h20); s.len = 2'd0;
        s.ifReq = 1'b1; s.ifAddr = AW'('h100);
        beginTxn(s); buildRead(1'b0, s, 0, '0); pinLast(1'b0, 32'h0000_00FF);
        s.memReq = 1'b0;
        buildRead(1'b1, s, 0, '0); pinLast(1'b1, 32'h0000_0013);

        s = quietStim(); s.memReq = 1'b1; s.memWr = 1'b1; s.memAddr = AW'('h30); s.len = 2'd1;
        s.wdata = 32'h0000_BEEF;
        beginTxn(s); buildWrite(s, 16'b0000_0000_0000_1100, 1'b0, 0);
        idleCycle();
        s = quietStim(); s.memReq = 1'b1; s.memAddr = AW'('h30); s.len = 2'd1;
        beginTxn(s); buildRead(1'b0, s, 0, '0); pinLast(1'b0, 32'h0000_BEEF);

        s = quietStim(); s.ifReq = 1'b1; s.ifAddr = AW'('h104);
        beginTxn(s); buildRead(1'b1, s, 2, AW'('h200));
        s.ifAddr = AW'('h200);
        beginTxn(s); buildRead(1'b1, s, 0, '0); pinLast(1'b1, 32'h1234_5678);

        s = quietStim(); s.memReq = 1'b1; s.memWr = 1'b1; s.memAddr = AW'('h40); s.len = 2'd2;
        s.wdata = 32'hAABB_CCDD;
        beginTxn(s); buildWrite(s, 16'd0, 1'b0, 2);
        s = quietStim(); s.memReq = 1'b1; s.memAddr = AW'('h40); s.len = 2'd2;
        beginTxn(s); buildRead(1'b0, s, 0, '0); pinLast(1'b0, 32'h4433_22DD);

        s = quietStim(); s.memReq = 1'b1; s.memAddr = AW'(RAMSZ - 2); s.len = 2'd3;
        beginTxn(s); buildRead(1'b0, s, 0, '0); pinLast(1'b0, 32'h0403_0201);

        repeat (150) begin
            repeat ($urandom_range(0, 2)) idleCycle();
            kind = $urandom_range(0, 9);
            s = quietStim();
            if (kind <= 2) begin
                s.memReq = 1'b1; s.memAddr = randAddr();
                beginTxn(s); buildRead(1'b0, s, 0, '0);
            end else if (kind <= 4 || kind == 9) begin
                s.memReq = 1'b1; s.memWr = 1'b1; s.memAddr = randAddr();
                beginTxn(s); buildWrite(s, 16'd0, 1'b1, (kind == 9) ? $urandom_range(1, 4) : 0);
            end else if (kind <= 7) begin
                s.ifReq = 1'b1; s.ifAddr = randAddr();
                beginTxn(s);
                if ($urandom_range(0, 2) == 0) begin
                    buildRead(1'b1, s, $urandom_range(1, 5), randAddr());
                    s.ifAddr = stimQ[stimQ.size()-1].ifAddr;
                    beginTxn(s);
                end
                buildRead(1'b1, s, 0, '0);
            end else begin
                s.memReq = 1'b1; s.memWr = 1'($urandom_range(0, 1)); s.memAddr = randAddr();
                s.ifReq = 1'b1; s.ifAddr = randAddr();
                beginTxn(s);
                if (s.memWr) buildWrite(s, 16'd0, 1'b1, 0);
                else         buildRead(1'b0, s, 0, '0);
                s.memReq = 1'b0;
                buildRead(1'b1, s, 0, '0);
            end
        end
        idleCycle(); idleCycle();
        built = 1'b1;

        for (int i = 0; i < stimQ.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(stimQ[i]);
        end
    end

    // Single checker: compares every DUT output to the expected record in the middle of each cycle.
    initial begin
        exp_t e;
        wait (built);
        for (int i = 0; i < expQ.size(); i++) begin
            @(negedge clk);
            e = expQ[i];
            checkOutput("busy", 32'(busy), 32'(e.busy), i);
            checkOutput("if_done", 32'(if_done), 32'(e.ifDone), i);
            checkOutput("mem_done", 32'(mem_done), 32'(e.memDone), i);
            checkOutput("ram_wr", 32'(ram_wr), 32'(e.wr), i);
            checkOutput("if_data", if_data, e.ifData, i);
            checkOutput("mem_data", mem_data, e.memData, i);
            if (e.chkAddr) checkOutput("ram_addr", 32'(ram_addr), 32'(e.addr), i);
            if (e.chkDout) checkOutput("ram_dout", 32'(ram_dout), 32'(e.dout), i);
            if (e.pinIf)   checkOutput("pinned_if_data", if_data, e.pinVal, i);
            if (e.pinMem)  checkOutput("pinned_mem_data", mem_data, e.pinVal, i);
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
